vend_arbiter: RTL and testbench

- Shares one physical dispenser between N customer panels. Each panel presents a product selection and its accumulated credit.
- Picks one requester round-robin, checks the price and drives the dispenser through a start/done handshake.
- Returns a per-panel acknowledge with a success flag, the product code and the change owed.
- Sits between the panel coin-accumulators and the dispenser mechanism.

---
 rtl/vend_pkg.sv | 41 ++++
 rtl/vend_arbiter_rr_arbiter.sv | 37 +++
 rtl/vend_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_vend_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vend_arbiter slice: product codes, default prices,
// controller state encoding and the product price lookup.
package vend_pkg;

  localparam int CREDIT_W = 5;

  localparam logic [1:0] PRODUCT_A = 2'b00;
  localparam logic [1:0] PRODUCT_B = 2'b01;
  localparam logic [1:0] PRODUCT_C = 2'b10;
  localparam logic [1:0] PRODUCT_D = 2'b11;

  localparam int DEFAULT_PRICE_A = 5;
  localparam int DEFAULT_PRICE_B = 10;
  localparam int DEFAULT_PRICE_C = 15;
  localparam int DEFAULT_PRICE_D = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT,
    ST_ACK
  } state_t;

  function automatic logic [CREDIT_W-1:0] price_lookup(
    input logic [1:0]          code,
    input logic [CREDIT_W-1:0] price_a,
    input logic [CREDIT_W-1:0] price_b,
    input logic [CREDIT_W-1:0] price_c,
    input logic [CREDIT_W-1:0] price_d
  );
    logic [CREDIT_W-1:0] price;
    case (code)
      PRODUCT_A: price = price_a;
      PRODUCT_B: price = price_b;
      PRODUCT_C: price = price_c;
      default:   price = price_d;
    endcase
    return price;
  endfunction

endpackage

// File: rtl/vend_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester after ptr,
// wrapping around, as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int                 cand;
  logic [IDX_W-1:0]   cand_idx;
  logic               found;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N; i++) begin
      cand     = (int'(ptr) + i) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/vend_arbiter.sv
// Shares one dispenser between N_PANELS panels: round-robin grant, price check,
// dispenser handshake and per-panel ack. Optional stock tracking: VEND_STOCK_EN.
module vend_arbiter
  import vend_pkg::*;
#(
  parameter int N_PANELS = 4,
  parameter int PRICE_A  = DEFAULT_PRICE_A,
  parameter int PRICE_B  = DEFAULT_PRICE_B,
  parameter int PRICE_C  = DEFAULT_PRICE_C,
  parameter int PRICE_D  = DEFAULT_PRICE_D
`ifdef VEND_STOCK_EN
  , parameter int STOCK_INIT = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PANELS-1:0]   req,
  input  logic [2*N_PANELS-1:0] sel,
  input  logic [5*N_PANELS-1:0] credit,
  output logic [N_PANELS-1:0]   ack,
  output logic                  ok,
  output logic [1:0]            product_out,
  output logic [4:0]            change_out,
  output logic                  disp_start,
  output logic [1:0]            disp_product,
  input  logic                  disp_done
`ifdef VEND_STOCK_EN
  , input  logic [3:0]          restock
  , output logic [3:0]          sold_out
`endif
);

  localparam int IDX_W = $clog2(N_PANELS);
  localparam logic [4:0] P_A = 5'(PRICE_A);
  localparam logic [4:0] P_B = 5'(PRICE_B);
  localparam logic [4:0] P_C = 5'(PRICE_C);
  localparam logic [4:0] P_D = 5'(PRICE_D);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          sel_q, sel_d;
  logic [4:0]          credit_q, credit_d;
  logic [N_PANELS-1:0] ack_q, ack_d;
  logic                ok_q, ok_d;
  logic [1:0]          product_q, product_d;
  logic [4:0]          change_q, change_d;
  logic                disp_start_q, disp_start_d;
  logic [1:0]          disp_product_q, disp_product_d;

  logic [N_PANELS-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                req_valid;
  logic [1:0]          cand_sel;
  logic [4:0]          cand_credit;
  logic [4:0]          cand_price;
  logic                stock_avail;
  logic                vend_now;

  rr_arbiter #(
    .N     (N_PANELS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .valid (req_valid)
  );

  // The price decision is taken on the granted panel's live inputs while in IDLE so
  // that disp_start is registered out on the same edge that latches the request.
  always_comb begin
    cand_sel    = '0;
    cand_credit = '0;
    for (int i = 0; i < N_PANELS; i++) begin
      if (grant[i]) begin
        cand_sel    = sel[2*i +: 2];
        cand_credit = credit[5*i +: 5];
      end
    end
    cand_price = price_lookup(cand_sel, P_A, P_B, P_C, P_D);
    vend_now   = (state_q == ST_IDLE) && req_valid && (cand_credit >= cand_price) && stock_avail;
  end

`ifdef VEND_STOCK_EN
  localparam logic [3:0] STOCK_FULL = 4'(STOCK_INIT);

  logic [3:0][3:0] stock_q, stock_d;
  logic [3:0]      sold_out_q, sold_out_d;

  always_comb begin
    stock_d    = stock_q;
    sold_out_d = '0;
    for (int p = 0; p < 4; p++) begin
      if (restock[p]) begin
        stock_d[p] = (vend_now && cand_sel == 2'(p)) ? STOCK_FULL - 4'd1 : STOCK_FULL;
      end else if (vend_now && cand_sel == 2'(p)) begin
        stock_d[p] = stock_q[p] - 4'd1;
      end
      sold_out_d[p] = (stock_d[p] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stock_q    <= {4{STOCK_FULL}};
      sold_out_q <= '0;
    end else begin
      stock_q    <= stock_d;
      sold_out_q <= sold_out_d;
    end
  end

  assign stock_avail = (stock_q[cand_sel] != '0);
  assign sold_out    = sold_out_q;
`else
  assign stock_avail = 1'b1;
`endif

  // CHECK reuses the IDLE decision carried in disp_start_q instead of re-pricing.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    idx_d          = idx_q;
    sel_d          = sel_q;
    credit_d       = credit_q;
    ack_d          = '0;
    ok_d           = 1'b0;
    product_d      = '0;
    change_d       = '0;
    disp_start_d   = 1'b0;
    disp_product_d = disp_product_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d    = grant_idx;
          sel_d    = cand_sel;
          credit_d = cand_credit;
          state_d  = ST_CHECK;
          if (vend_now) begin
            disp_start_d   = 1'b1;
            disp_product_d = cand_sel;
          end
        end
      end
      ST_CHECK: begin
        if (disp_start_q) begin
          state_d = ST_WAIT;
        end else begin
          state_d      = ST_ACK;
          ack_d[idx_q] = 1'b1;
          product_d    = sel_q;
          change_d     = credit_q;
        end
      end
      ST_WAIT: begin
        if (disp_done) begin
          state_d      = ST_ACK;
          ack_d[idx_q] = 1'b1;
          ok_d         = 1'b1;
          product_d    = sel_q;
          change_d     = credit_q - price_lookup(sel_q, P_A, P_B, P_C, P_D);
        end
      end
      ST_ACK: begin
        ptr_d   = idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      idx_q          <= '0;
      sel_q          <= '0;
      credit_q       <= '0;
      ack_q          <= '0;
      ok_q           <= 1'b0;
      product_q      <= '0;
      change_q       <= '0;
      disp_start_q   <= 1'b0;
      disp_product_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      sel_q          <= sel_d;
      credit_q       <= credit_d;
      ack_q          <= ack_d;
      ok_q           <= ok_d;
      product_q      <= product_d;
      change_q       <= change_d;
      disp_start_q   <= disp_start_d;
      disp_product_q <= disp_product_d;
    end
  end

  assign ack          = ack_q;
  assign ok           = ok_q;
  assign product_out  = product_q;
  assign change_out   = change_q;
  assign disp_start   = disp_start_q;
  assign disp_product = disp_product_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Randomised self-checking bench for vend_arbiter, compared against a
// transaction-level model of the round-robin, pricing and change rules.
module tb_vend_arbiter;

  localparam int N             = 4;
  localparam int STOCK_INIT_TB = 2;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req;
  logic [2*N-1:0] sel;
  logic [5*N-1:0] credit;
  logic           disp_done;
  logic [N-1:0]   ack;
  logic           ok;
  logic [1:0]     product_out;
  logic [4:0]     change_out;
  logic           disp_start;
  logic [1:0]     disp_product;
`ifdef VEND_STOCK_EN
  logic [3:0]     restock;
  logic [3:0]     sold_out;
`endif

  int checks = 0;
  int errors = 0;
  int model_ptr;
  int last_winner;
  int panel_sel[N];
  int panel_credit[N];
  int price_tab[4] = '{5, 10, 15, 20};
  int stock[4];

  always #5 clk = ~clk;

  vend_arbiter #(
    .N_PANELS(N)
`ifdef VEND_STOCK_EN
    , .STOCK_INIT(STOCK_INIT_TB)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .sel          (sel),
    .credit       (credit),
    .ack          (ack),
    .ok           (ok),
    .product_out  (product_out),
    .change_out   (change_out),
    .disp_start   (disp_start),
    .disp_product (disp_product),
    .disp_done    (disp_done)
`ifdef VEND_STOCK_EN
    , .restock    (restock)
    , .sold_out   (sold_out)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelWinner(input logic [N-1:0] mask, input int ptr);
    for (int i = 1; i <= N; i++) begin
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      sel[2*i +: 2]    = 2'(panel_sel[i]);
      credit[5*i +: 5] = 5'(panel_credit[i]);
    end
  endtask

  task automatic setPanel(input int p, input int s, input int c);
    req[p]          = 1'b1;
    panel_sel[p]    = s;
    panel_credit[p] = c;
    driveInputs();
  endtask

  task automatic resetModel();
    model_ptr   = 0;
    last_winner = -1;
    for (int p = 0; p < 4; p++) stock[p] = STOCK_INIT_TB;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Raises fresh requests on idle panels; the panel acked this cycle stays low.
  task automatic applyStimulus();
    int pick;
    for (int i = 0; i < N; i++) begin
      if (!req[i] && i != last_winner && $urandom_range(0, 1) == 1) begin
        req[i]       = 1'b1;
        panel_sel[i] = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0:       panel_credit[i] = price_tab[panel_sel[i]];
          1:       panel_credit[i] = price_tab[panel_sel[i]] - 1;
          default: panel_credit[i] = $urandom_range(0, 31);
        endcase
      end
    end
    if (req == '0) begin
      pick = (last_winner + 1 + $urandom_range(0, N - 2)) % N;
      req[pick]          = 1'b1;
      panel_sel[pick]    = $urandom_range(0, 3);
      panel_credit[pick] = $urandom_range(0, 31);
    end
    driveInputs();
  endtask

  // One arbitration round; from_ack adds the IDLE cycle that follows an ack.
  task automatic runTxn(input bit from_ack, input int done_delay, input bit spurious, input bit perturb);
    int w, s, cr, price;
    bit vend;
    w     = modelWinner(req, model_ptr);
    s     = panel_sel[w];
    cr    = panel_credit[w];
    price = price_tab[s];
    vend  = (cr >= price);
`ifdef VEND_STOCK_EN
    vend = vend && (stock[s] > 0);
    if (vend) stock[s]--;
`endif
    if (from_ack) begin
      @(negedge clk);
      checkOutput("idle_ack", 32'(ack), 32'(0));
    end
    @(negedge clk);
    checkOutput("disp_start", 32'(disp_start), 32'(vend));
    checkOutput("ack_cycle1", 32'(ack), 32'(0));
    if (vend) checkOutput("disp_product", 32'(disp_product), 32'(s));
    disp_done = spurious;
    @(negedge clk);
    disp_done = 1'b0;
    if (vend) begin
      for (int c = 0; c < done_delay; c++) begin
        checkOutput("wait_ack", 32'(ack), 32'(0));
        checkOutput("wait_start", 32'(disp_start), 32'(0));
        if (perturb && c == 0) begin
          req[w]          = 1'b0;
          panel_sel[w]    = $urandom_range(0, 3);
          panel_credit[w] = $urandom_range(0, 31);
          driveInputs();
        end
        @(negedge clk);
      end
      checkOutput("hold_product", 32'(disp_product), 32'(s));
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
    end
    checkOutput("ack", 32'(ack), 32'(1 << w));
    checkOutput("ok", 32'(ok), 32'(vend));
    checkOutput("product_out", 32'(product_out), 32'(s));
    checkOutput("change_out", 32'(change_out), 32'(vend ? cr - price : cr));
    req[w]      = 1'b0;
    model_ptr   = w;
    last_winner = w;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req       = '0;
    sel       = '0;
    credit    = '0;
    disp_done = 1'b0;
`ifdef VEND_STOCK_EN
    restock   = '0;
`endif
    for (int i = 0; i < N; i++) begin
      panel_sel[i]    = 0;
      panel_credit[i] = 0;
    end
    applyReset();
    checkOutput("rst_ack", 32'(ack), 32'(0));
    checkOutput("rst_ok", 32'(ok), 32'(0));
    checkOutput("rst_product", 32'(product_out), 32'(0));
    checkOutput("rst_change", 32'(change_out), 32'(0));
    checkOutput("rst_disp_start", 32'(disp_start), 32'(0));
    checkOutput("rst_disp_product", 32'(disp_product), 32'(0));

    // Directed: vend with change, then an underfunded reject.
    setPanel(0, 0, 10);
    runTxn(1'b0, 2, 1'b0, 1'b0);
    setPanel(2, 3, 15);
    runTxn(1'b1, 0, 1'b0, 1'b0);

    // Reset while waiting on the dispenser abandons the round.
    applyReset();
    setPanel(3, 1, 31);
    @(negedge clk);
    checkOutput("pre_rst_start", 32'(disp_start), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ack", 32'(ack), 32'(0));
    checkOutput("mid_rst_ok", 32'(ok), 32'(0));
    checkOutput("mid_rst_change", 32'(change_out), 32'(0));
    checkOutput("mid_rst_start", 32'(disp_start), 32'(0));
    checkOutput("mid_rst_disp_product", 32'(disp_product), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    resetModel();
    runTxn(1'b0, 1, 1'b1, 1'b0);

    // All panels requesting: service order follows the pointer.
    applyReset();
    setPanel(0, 0, 5);
    setPanel(1, 1, 12);
    setPanel(2, 2, 20);
    setPanel(3, 3, 25);
    runTxn(1'b0, 0, 1'b0, 1'b0);
    repeat (3) runTxn(1'b1, 0, 1'b0, 1'b0);

    setPanel(1, 2, 15);
    runTxn(1'b1, 0, 1'b0, 1'b0);

    repeat (40) begin
      applyStimulus();
      runTxn(1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef VEND_STOCK_EN
    applyReset();
    req = '0;
    setPanel(0, 0, 10);
    setPanel(1, 0, 10);
    setPanel(2, 0, 10);
    runTxn(1'b0, 0, 1'b0, 1'b0);
    runTxn(1'b1, 0, 1'b0, 1'b0);
    runTxn(1'b1, 0, 1'b0, 1'b0);
    checkOutput("sold_out0", 32'(sold_out[0]), 32'(1));
    restock = 4'b0001;
    @(negedge clk);
    restock  = '0;
    stock[0] = STOCK_INIT_TB;
    checkOutput("restocked0", 32'(sold_out[0]), 32'(0));
    setPanel(3, 0, 5);
    runTxn(1'b0, 1, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
